figure_select_ctrl: RTL and testbench
=====================================

FIGURE_SELECT_CTRL -- requirements
Module: figure_select_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000, sets the debounce stability window in clk cycles (10 ms at 50 MHz).
REQ-002 Parameter FULL_FRAMES, default 300, sets the auto-return timeout in frames (used only with AUTO_RETURN_EN).
REQ-003 clk  input  1  system clock; all state is in this single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_up, btn_down, btn_left, btn_right, btn_enter  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 frame_tick  input  1  one-clk pulse at the start of vertical blanking.
REQ-007 circle_select, square_select, triangle_select, oval_select, rectangle_select, diamond_select, hexagon_select, pentagon_select, star_select  output  1 each  one-hot figure select for the renderer.
REQ-008 full_screen  output  1  selected figure drawn full screen.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer and then a debouncer that accepts a new level only after DB_CYCLES consecutive identical samples.
REQ-010 Each debounced button SHALL produce a one-clk press pulse on its rising edge only; held buttons produce no repeats.
REQ-011 Cursor SHALL be row (0..2) and col (0..2); index = row*3+col maps 0..8 to circle, square, triangle, oval, rectangle, diamond, hexagon, pentagon, star.
REQ-012 FSM states: GRID and FULL.
REQ-013 In GRID, up/down SHALL decrement/increment row and left/right SHALL decrement/increment col, with wrap-around (0-1 -> 2, 2+1 -> 0).
REQ-014 In GRID, enter SHALL move to FULL without changing the cursor.
REQ-015 In FULL, enter SHALL return to GRID; direction presses SHALL be ignored.
REQ-016 With simultaneous press pulses in one cycle, exactly one SHALL act, by priority enter > up > down > left > right; the others are discarded.
REQ-017 State and cursor SHALL update in the clk cycle after the press pulse.
REQ-018 The select outputs and full_screen SHALL be registered shadows, loaded from cursor/state only in the cycle frame_tick=1 and visible the following cycle; no output changes mid-frame.
REQ-019 Exactly one select output SHALL be high at all times after reset.
REQ-020 Multiple cursor moves between frame_ticks SHALL all take effect; only the final value at frame_tick is shown.
REQ-021 A press pulse coinciding with frame_tick SHALL update the cursor first; the shadow loads the pre-press value, and the new value appears at the next frame_tick.

Reset
REQ-022 Reset SHALL force state GRID, row=0, col=0, circle_select=1, other selects=0, full_screen=0, synchronizers/debouncers to the released (0) level, and all counters to 0.
REQ-023 Reset asserted mid-debounce or in FULL SHALL abort the operation immediately; a button held through reset release SHALL NOT generate a press until it is released and pressed again.

Configuration
REQ-024 Macro AUTO_RETURN_EN: when defined, a frame counter SHALL clear on FULL entry, increment on each frame_tick in FULL, and force a return to GRID when it reaches FULL_FRAMES; a FULL-entry enter press also clears it.
REQ-025 Without AUTO_RETURN_EN, the counter SHALL not exist and FULL SHALL be left only by enter or reset.

Verification (DB_CYCLES=4, FULL_FRAMES=3 for simulation)
REQ-026 Reset release, then one frame_tick -> circle_select=1, others 0, full_screen=0.
REQ-027 Press right twice (each held 6 clk, released 6 clk), then frame_tick -> triangle_select=1; third right press, then frame_tick -> circle_select=1 (col wrap).
REQ-028 up from row 0, then frame_tick -> hexagon_select=1 (row wrap to 2); 3-clk glitch on btn_down -> no change.
REQ-029 enter and left asserted in the same cycle, then frame_tick -> full_screen=1 with cursor unchanged; left while in FULL -> ignored; enter, then frame_tick -> full_screen=0.
REQ-030 With AUTO_RETURN_EN: enter FULL, then 3 frame_ticks -> GRID, and full_screen=0 after the next tick; without the macro -> full_screen stays 1 after 10 ticks.
REQ-031 Reset pulse while in FULL with btn_enter held through release -> GRID, circle_select=1, no FULL entry until enter is released and pressed again.

Source files
------------

// File: rtl/figure_select_ctrl.sv
// figure_select_ctrl: five debounced push-buttons move a cursor over a 3x3
// grid of figures. Enter toggles between the grid view and full-screen view.
// The renderer-facing outputs are shadows that change only on frame_tick.
// Optional feature macro: AUTO_RETURN_EN. When it is defined, the block leaves
// full-screen mode by itself after FULL_FRAMES frames.
module figure_select_ctrl #(
    parameter int unsigned DB_CYCLES   = 500000,
    parameter int unsigned FULL_FRAMES = 300
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_enter,
    input  logic frame_tick,
    output logic circle_select,
    output logic square_select,
    output logic triangle_select,
    output logic oval_select,
    output logic rectangle_select,
    output logic diamond_select,
    output logic hexagon_select,
    output logic pentagon_select,
    output logic star_select,
    output logic full_screen
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    // Arming needs DB_CYCLES zero samples after reset, and the first two
    // samples come from reset-cleared synchronizer flops. DB_CYCLES therefore
    // has to exceed the synchronizer depth.
    if (DB_CYCLES < 3 || FULL_FRAMES < 1) begin : g_cfg_check
        $error("figure_select_ctrl: DB_CYCLES must be >= 3 and FULL_FRAMES >= 1");
    end

    typedef enum logic {GRID, FULL} state_t;

    // Bit order: 0 up, 1 down, 2 left, 3 right, 4 enter
    logic [4:0]           btn_raw;
    logic [4:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic [4:0]           lvl_q, lvl_d, prev_q, prev_d, armed_q, armed_d;
    logic [4:0][DB_W-1:0] cnt_q, cnt_d;
    logic [4:0]           press;

    state_t     state_q, state_d;
    logic [1:0] row_q, row_d, col_q, col_d;
    logic [8:0] sel_q, sel_d;
    logic       full_q, full_d;
    logic [3:0] idx;

    assign btn_raw = {btn_enter, btn_right, btn_left, btn_down, btn_up};

    // Synchronise, debounce and edge-detect each button.
    // A button stays disarmed after reset until it is seen released for a
    // full debounce window. This keeps a button that is held through reset
    // release from producing a press.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = lvl_q;
        lvl_d   = lvl_q;
        armed_d = armed_q;
        cnt_d   = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (!armed_q[i]) begin
                if (!sync2_q[i]) begin
                    if (cnt_q[i] == DB_MAX) armed_d[i] = 1'b1;
                    else                    cnt_d[i]   = cnt_q[i] + 1'b1;
                end
            end else if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DB_MAX) lvl_d[i] = sync2_q[i];
                else                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        press = lvl_q & ~prev_q;
    end

`ifdef AUTO_RETURN_EN
    localparam int unsigned FRM_W = $clog2(FULL_FRAMES + 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FULL_FRAMES - 1);
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
`endif

    // Next state and cursor. Only the highest-priority press pulse acts.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
`ifdef AUTO_RETURN_EN
        frm_cnt_d = frm_cnt_q;
`endif
        if (press[4]) begin
            state_d = (state_q == GRID) ? FULL : GRID;
`ifdef AUTO_RETURN_EN
            frm_cnt_d = '0;
`endif
        end else if (state_q == GRID) begin
            if (press[0])      row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
            else if (press[1]) row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
            else if (press[2]) col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
            else if (press[3]) col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end
`ifdef AUTO_RETURN_EN
        else if (frame_tick) begin
            if (frm_cnt_q == FRM_LAST) begin
                state_d   = GRID;
                frm_cnt_d = '0;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
`endif
    end

    // Output shadows are loaded from the current registered cursor and state.
    // A press in the frame_tick cycle therefore shows one frame later.
    always_comb begin
        idx    = ({2'b00, row_q} * 4'd3) + {2'b00, col_q};
        sel_d  = sel_q;
        full_d = full_q;
        if (frame_tick) begin
            sel_d  = 9'd1 << idx;
            full_d = (state_q == FULL);
        end
    end

    // All state registers, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            cnt_q   <= '0;
            state_q <= GRID;
            row_q   <= '0;
            col_q   <= '0;
            sel_q   <= 9'd1;
            full_q  <= 1'b0;
`ifdef AUTO_RETURN_EN
            frm_cnt_q <= '0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sel_q   <= sel_d;
            full_q  <= full_d;
`ifdef AUTO_RETURN_EN
            frm_cnt_q <= frm_cnt_d;
`endif
        end
    end

    assign circle_select    = sel_q[0];
    assign square_select    = sel_q[1];
    assign triangle_select  = sel_q[2];
    assign oval_select      = sel_q[3];
    assign rectangle_select = sel_q[4];
    assign diamond_select   = sel_q[5];
    assign hexagon_select   = sel_q[6];
    assign pentagon_select  = sel_q[7];
    assign star_select      = sel_q[8];
    assign full_screen      = full_q;

endmodule

// File: tb/tb_figure_select_ctrl.sv
// Directed self-checking bench for figure_select_ctrl (DB_CYCLES=4, FULL_FRAMES=3).
// It covers both builds: with and without AUTO_RETURN_EN.
module tb_figure_select_ctrl;

    localparam logic [4:0] UP    = 5'b00001;
    localparam logic [4:0] DOWN  = 5'b00010;
    localparam logic [4:0] LEFT  = 5'b00100;
    localparam logic [4:0] RIGHT = 5'b01000;
    localparam logic [4:0] ENTER = 5'b10000;

    localparam logic [8:0] CIRCLE   = 9'h001;
    localparam logic [8:0] SQUARE   = 9'h002;
    localparam logic [8:0] TRIANGLE = 9'h004;
    localparam logic [8:0] HEXAGON  = 9'h040;
    localparam logic [8:0] STAR     = 9'h100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic [4:0] btn = '0;
    logic circle_s, square_s, triangle_s, oval_s, rect_s, diamond_s;
    logic hexagon_s, pentagon_s, star_s, full_s;
    logic [8:0] sel;
    int checks = 0;
    int errors = 0;

    assign sel = {star_s, pentagon_s, hexagon_s, diamond_s, rect_s,
                  oval_s, triangle_s, square_s, circle_s};

    always #5 clk = ~clk;

    figure_select_ctrl #(.DB_CYCLES(4), .FULL_FRAMES(3)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]),
        .btn_right(btn[3]), .btn_enter(btn[4]),
        .frame_tick(frame_tick),
        .circle_select(circle_s), .square_select(square_s),
        .triangle_select(triangle_s), .oval_select(oval_s),
        .rectangle_select(rect_s), .diamond_select(diamond_s),
        .hexagon_select(hexagon_s), .pentagon_select(pentagon_s),
        .star_select(star_s), .full_screen(full_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold the buttons in mask for 6 clk, then release them for 6 clk.
    task automatic press(input logic [4:0] mask);
        @(negedge clk) btn = mask;
        repeat (6) @(negedge clk);
        btn = '0;
        repeat (6) @(negedge clk);
    endtask

    // Pulse frame_tick once. The outputs are valid when the task returns.
    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel), 32'(CIRCLE));
        check("rst_full", 32'(full_s), 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        tick();
        check("init_sel", 32'(sel), 32'(CIRCLE));
        check("init_full", 32'(full_s), 32'd0);

        // Column moves and column wrap
        press(RIGHT);
        press(RIGHT);
        tick();
        check("right2", 32'(sel), 32'(TRIANGLE));
        press(RIGHT);
        tick();
        check("col_wrap", 32'(sel), 32'(CIRCLE));

        // Row wrap upward, then a short glitch that must be rejected
        press(UP);
        tick();
        check("row_wrap_up", 32'(sel), 32'(HEXAGON));
        @(negedge clk) btn = DOWN;
        repeat (3) @(negedge clk);
        btn = '0;
        repeat (10) @(negedge clk);
        tick();
        check("glitch", 32'(sel), 32'(HEXAGON));

        // Enter beats left. Directions are ignored in FULL.
        press(ENTER | LEFT);
        tick();
        check("enter_pri_full", 32'(full_s), 32'd1);
        check("enter_pri_sel", 32'(sel), 32'(HEXAGON));
        press(LEFT);
        tick();
        check("full_left_full", 32'(full_s), 32'd1);
        check("full_left_sel", 32'(sel), 32'(HEXAGON));
        press(ENTER);
        tick();
        check("exit_full", 32'(full_s), 32'd0);
        check("exit_sel", 32'(sel), 32'(HEXAGON));

        // Several moves between ticks: down wraps row 2 -> 0, then right
        press(DOWN);
        press(RIGHT);
        tick();
        check("multi_move", 32'(sel), 32'(SQUARE));
        press(LEFT);
        press(LEFT);
        tick();
        check("left_wrap", 32'(sel), 32'(TRIANGLE));

        // Up beats down: row 0 -> 2, col 2
        press(UP | DOWN);
        tick();
        check("up_pri", 32'(sel), 32'(STAR));
        press(DOWN);
        tick();
        check("row_wrap_dn", 32'(sel), 32'(TRIANGLE));

        // Press pulse coincides with frame_tick. The pulse occurs after the
        // 6th negedge of the hold.
        @(negedge clk) btn = RIGHT;
        repeat (6) @(negedge clk);
        btn = '0;
        frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        check("coinc_old", 32'(sel), 32'(TRIANGLE));
        repeat (8) @(negedge clk);
        tick();
        check("coinc_new", 32'(sel), 32'(CIRCLE));

        // Leaving FULL: by timeout with AUTO_RETURN_EN, otherwise only by enter
        press(ENTER);
        tick();
        check("full_t1", 32'(full_s), 32'd1);
`ifdef AUTO_RETURN_EN
        tick();
        tick();
        check("full_t3", 32'(full_s), 32'd1);
        tick();
        check("auto_ret", 32'(full_s), 32'd0);
        check("auto_ret_sel", 32'(sel), 32'(CIRCLE));
`else
        repeat (9) tick();
        check("full_t10", 32'(full_s), 32'd1);
        press(ENTER);
        tick();
        check("enter_ret", 32'(full_s), 32'd0);
`endif

        // Reset while in FULL, with enter held through reset release
        press(ENTER);
        tick();
        check("pre_rst_full", 32'(full_s), 32'd1);
        @(negedge clk) reset = 1'b1;
        btn = ENTER;
        repeat (3) @(negedge clk);
        check("rst2_full", 32'(full_s), 32'd0);
        check("rst2_sel", 32'(sel), 32'(CIRCLE));
        reset = 1'b0;
        repeat (12) @(negedge clk);
        tick();
        check("held_full", 32'(full_s), 32'd0);
        check("held_sel", 32'(sel), 32'(CIRCLE));
        btn = '0;
        repeat (10) @(negedge clk);
        press(ENTER);
        tick();
        check("repress_full", 32'(full_s), 32'd1);
        check("repress_sel", 32'(sel), 32'(CIRCLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
